// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Raster timing generator. It divides the system clock down to a one-cycle
// pixel strobe and runs the horizontal/vertical pixel counters. From those
// counters it produces the registered sync, blank and frame markers for the
// VGA DAC and connector. The defaults give 640x480 @ 60 Hz from 50 MHz.
//
// Ports:
//   clk          system clock, everything changes on its rising edge
//   rst_n        asynchronous active-low reset
//   pix_en       one-clk strobe: the current (x,y) pixel is consumed now
//   vga_clk      registered, glitch-free pixel clock for the DAC
//   x, y         current horizontal / vertical count (10 bits each)
//   hsync_n      horizontal sync, active low
//   vsync_n      vertical sync, active low
//   blank_n      high only while (x,y) lies inside the visible area
//   sync_n       DAC composite sync, tied low
//   frame_start  one-clk strobe on the first pixel (0,0) of every frame
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // A divide-by-1 still needs a one-bit counter so the ports stay legal.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic             DIV_ON   = (CLK_DIV > 1);
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic [31:0]      x_ext;
  logic [31:0]      y_ext;

  assign pix_en      = (div_cnt == DIV_LAST);
  assign frame_start = pix_en && (x == 10'd0) && (y == 10'd0);
  assign sync_n      = 1'b0;

  // Next-state counts. The decodes are registered from these so each decode
  // lands in the same cycle as the x/y it describes, with no comb glitches.
  always_comb begin
    div_next = div_cnt;
    x_next   = x;
    y_next   = y;
    if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end else begin
      div_next = div_cnt + 1'b1;
    end
    if (pix_en) begin
      if (x == X_LAST) begin
        x_next = '0;
        if (y == Y_LAST) begin
          y_next = '0;
        end else begin
          y_next = y + 1'b1;
        end
      end else begin
        x_next = x + 1'b1;
      end
    end
  end

  assign x_ext = {22'd0, x_next};
  assign y_ext = {22'd0, y_next};

  // Counter and decode registers. vga_clk follows the divider phase one
  // cycle ahead so it is high for the upper half of each pixel period; with
  // CLK_DIV=1 the DAC runs on clk directly and vga_clk stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      x       <= '0;
      y       <= '0;
      vga_clk <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      blank_n <= 1'b1;
    end else begin
      div_cnt <= div_next;
      x       <= x_next;
      y       <= y_next;
      vga_clk <= DIV_ON && (div_next >= DIV_HALF);
      hsync_n <= !((x_ext >= HS_START) && (x_ext < HS_END));
      vsync_n <= !((y_ext >= VS_START) && (y_ext < VS_END));
      blank_n <= (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Drives four vga_timing instances from one clock and one reset:
//   A: defaults (640x480, divide by 2)
//   B: tiny raster 4/1/2/1 x 3/1/1/1, divide by 1 (48-clock frame)
//   C: default raster, divide by 3 (2400-clock line)
//   D: small raster 16/2/3/3 x 10/2/2/2, divide by 2 (768-clock frame)
// Expected outputs come from a closed-form model of the edge count since
// reset release; they are queued on each rising edge and compared on the
// following falling edge. A vector table pins down the line timing of A.
// ---------------------------------------------------------------------------
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] pixEn, vgaClk, hsyncN, vsyncN, blankN, syncN, frameStart;
  logic [9:0] xs [4];
  logic [9:0] ys [4];

  vga_timing dutA (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEn[0]), .vga_clk(vgaClk[0]),
    .x(xs[0]), .y(ys[0]), .hsync_n(hsyncN[0]), .vsync_n(vsyncN[0]),
    .blank_n(blankN[0]), .sync_n(syncN[0]), .frame_start(frameStart[0]));

  vga_timing #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
               .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dutB (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEn[1]), .vga_clk(vgaClk[1]),
    .x(xs[1]), .y(ys[1]), .hsync_n(hsyncN[1]), .vsync_n(vsyncN[1]),
    .blank_n(blankN[1]), .sync_n(syncN[1]), .frame_start(frameStart[1]));

  vga_timing #(.CLK_DIV(3)) dutC (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEn[2]), .vga_clk(vgaClk[2]),
    .x(xs[2]), .y(ys[2]), .hsync_n(hsyncN[2]), .vsync_n(vsyncN[2]),
    .blank_n(blankN[2]), .sync_n(syncN[2]), .frame_start(frameStart[2]));

  vga_timing #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
               .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)) dutD (
    .clk(clk), .rst_n(rst_n), .pix_en(pixEn[3]), .vga_clk(vgaClk[3]),
    .x(xs[3]), .y(ys[3]), .hsync_n(hsyncN[3]), .vsync_n(vsyncN[3]),
    .blank_n(blankN[3]), .sync_n(syncN[3]), .frame_start(frameStart[3]));

  typedef struct packed {
    logic       pix_en;
    logic       vga_clk;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
    obs_t d;
  } snap_t;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       pe;
    logic       hs;
    logic       bl;
    logic       fs;
  } vec_t;

  snap_t sbq [$];
  vec_t  vecs [11];
  int    edgeCount = 0;
  int    checks = 0;
  int    errors = 0;
  int    lastA = -1;
  int    lastB = -1;
  int    lastC = -1;
  int    lastD = -1;

  // Closed-form expectation after n rising edges since reset release.
  function automatic obs_t model(int d, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, int n);
    obs_t e;
    int ht, vt, p, ph, xx, yy;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = n / d;
    ph = n % d;
    xx = p % ht;
    yy = (p / ht) % vt;
    e.pix_en      = (ph == d - 1);
    e.vga_clk     = (d > 1) && (ph >= d / 2);
    e.x           = 10'(xx);
    e.y           = 10'(yy);
    e.hsync_n     = !((xx >= ha + hf) && (xx < ha + hf + hs));
    e.vsync_n     = !((yy >= va + vf) && (yy < va + vf + vs));
    e.blank_n     = (xx < ha) && (yy < va);
    e.sync_n      = 1'b0;
    e.frame_start = e.pix_en && (xx == 0) && (yy == 0);
    return e;
  endfunction

  function automatic snap_t expectAll(int n);
    snap_t s;
    s.a = model(2, 640, 16, 96, 48, 480, 10, 2, 33, n);
    s.b = model(1, 4, 1, 2, 1, 3, 1, 1, 1, n);
    s.c = model(3, 640, 16, 96, 48, 480, 10, 2, 33, n);
    s.d = model(2, 16, 2, 3, 3, 10, 2, 2, 2, n);
    return s;
  endfunction

  function automatic obs_t actual(int i);
    return {pixEn[i], vgaClk[i], xs[i], ys[i], hsyncN[i], vsyncN[i],
            blankN[i], syncN[i], frameStart[i]};
  endfunction

  function automatic obs_t resetValue(logic divOne);
    obs_t r;
    r = '0;
    r.pix_en      = divOne;
    r.hsync_n     = 1'b1;
    r.vsync_n     = 1'b1;
    r.blank_n     = 1'b1;
    r.frame_start = divOne;
    return r;
  endfunction

  task automatic checkOutput(input string nm, input int idx, input obs_t want);
    obs_t got;
    got = actual(idx);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s n=%0d got=%h want=%h", nm, edgeCount, got, want);
    end
  endtask

  // Spacing between repeated events (line or frame starts) in clocks.
  task automatic track(input logic ev, inout int last, input int period,
                       input string nm);
    if (!rst_n) begin
      last = -1;
    end else if (ev) begin
      if (last >= 0) begin
        checks++;
        if (edgeCount - last != period) begin
          errors++;
          $display("[TB] FAIL %s period got=%0d want=%0d", nm,
                   edgeCount - last, period);
        end
      end
      last = edgeCount;
    end
  endtask

  // One clock: queue the expectation at the rising edge, compare the DUT
  // outputs at the falling edge.
  task automatic applyStimulus();
    snap_t s;
    @(posedge clk);
    if (!rst_n) edgeCount = 0;
    else        edgeCount++;
    sbq.push_back(expectAll(edgeCount));
    @(negedge clk);
    s = sbq.pop_front();
    checkOutput("A", 0, s.a);
    checkOutput("B", 1, s.b);
    checkOutput("C", 2, s.c);
    checkOutput("D", 3, s.d);
    track(pixEn[0] && xs[0] == 10'd0, lastA, 1600, "lineA");
    track(frameStart[1], lastB, 48, "frameB");
    track(pixEn[2] && xs[2] == 10'd0, lastC, 2400, "lineC");
    track(frameStart[3], lastD, 768, "frameD");
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_A"}, 0, resetValue(1'b0));
    checkOutput({tag, "_B"}, 1, resetValue(1'b1));
    checkOutput({tag, "_C"}, 2, resetValue(1'b0));
    checkOutput({tag, "_D"}, 3, resetValue(1'b0));
  endtask

  initial begin
    vecs[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1503, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1504, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1601, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset asserted between edges: outputs must settle with no clock.
    #2 rst_n = 1'b0;
    #1 checkReset("rst_init");
    repeat (3) applyStimulus();
    #2 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      logic [25:0] got, want;
      while (edgeCount < vecs[i].n) applyStimulus();
      got  = {pixEn[0], xs[0], ys[0], hsyncN[0], blankN[0], frameStart[0], 1'b0};
      want = {vecs[i].pe, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].bl,
              vecs[i].fs, 1'b0};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL vec%0d n=%0d got=%h want=%h", i, edgeCount, got, want);
      end
    end

    while (edgeCount < 5000) applyStimulus();

    // Reset in the middle of D's frame, held for three clocks.
    begin
      int guard;
      guard = 0;
      while (ys[3] != 10'd8 && guard < 2000) begin
        applyStimulus();
        guard++;
      end
      checks++;
      if (ys[3] != 10'd8) begin
        errors++;
        $display("[TB] FAIL wait_y8 got=%0d want=8", ys[3]);
      end
    end
    #2 rst_n = 1'b0;
    #1 checkReset("rst_mid");
    repeat (3) applyStimulus();
    #2 rst_n = 1'b1;
    repeat (1700) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
